// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared CPU types and constants for the fetch stage
package instr_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // An address is unusable if it is not word-aligned or falls past the end of imem.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register carrying instruction, pc and pc+4 between stages
module if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  pc4,
    output logic [W-1:0] instr_q,
    output logic [31:0]  pc_q,
    output logic [31:0]  pc4_q,
    output logic         valid_q
);

    // Flush only invalidates; the payload is left as-is so it holds for debug visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            instr_q <= instr;
            pc_q    <= pc;
            pc4_q   <= pc4;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC sequencing, redirect, halt and fault
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               halted,
    output logic               fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;
    logic         redirect_bad;
    logic         seq_bad;
    logic         capture_en;
    logic         capture_flush;

    assign pc_seq       = pc + PC_INC;
    assign redirect_bad = addr_bad(redirect_pc, IMEM_WORDS);
    assign seq_bad      = addr_bad(pc_seq, IMEM_WORDS);
    assign imem_addr    = pc;

    always_comb begin
        capture_en    = 1'b0;
        capture_flush = 1'b0;
        case (state)
            ST_RUN: begin
                if (redirect_valid) begin
                    capture_flush = 1'b1;
                end else if (halt_req || !stall) begin
                    capture_en = 1'b1;
                end
            end
            ST_HALTED: capture_flush = 1'b1;
            default: begin
                capture_en    = 1'b0;
                capture_flush = 1'b0;
            end
        endcase
    end

    // A bad sequential target still lets the current word be captured; only the PC stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_START;
            pc     <= RESET_PC;
            fault  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect_valid) begin
                        if (redirect_bad) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (halt_req) begin
                        halted <= 1'b1;
                        state  <= ST_HALTED;
                    end else if (!stall) begin
                        if (seq_bad) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end else begin
                            pc <= pc_seq;
                        end
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_START;
            endcase
        end
    end

    if_id_reg #(
        .W(INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (capture_en),
        .flush   (capture_flush),
        .instr   (imem_data),
        .pc      (pc),
        .pc4     (pc_seq),
        .instr_q (if_id_instr),
        .pc_q    (if_id_pc),
        .pc4_q   (if_id_pc4),
        .valid_q (if_id_valid)
    );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 Parameter IMEM_WORDS, default 1024, number of 32-bit words in the instruction memory.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hold PC and IF/ID contents this cycle.
REQ-006 redirect_valid  input  1  load a new PC (branch/jump taken).
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 halt_req  input  1  stop fetching after the current cycle.
REQ-009 imem_addr  output  32  byte address to instruction memory; equals current PC.
REQ-010 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-011 if_id_instr  output  32  registered instruction for decode.
REQ-012 if_id_pc  output  32  registered PC of if_id_instr.
REQ-013 if_id_pc4  output  32  registered if_id_pc + 4.
REQ-014 if_id_valid  output  1  if_id_* holds a real instruction.
REQ-015 halted  output  1  fetch FSM is in HALTED.
REQ-016 fault  output  1  sticky: fetch stopped on misaligned or out-of-range address.

Function
REQ-017 FSM states SHALL be START, RUN, HALTED.
REQ-018 START lasts exactly one cycle after rst_n deasserts; no capture, PC held at RESET_PC; next state RUN.
REQ-019 In RUN with no stall/redirect: PC <= PC + 4 (mod 2^32); IF/ID <= {imem_data, PC, PC+4}; if_id_valid <= 1.
REQ-020 Fetch latency: instruction at address A SHALL appear on if_id_instr one clock after PC = A.
REQ-021 stall=1 in RUN: PC and all IF/ID outputs hold.
REQ-022 redirect_valid=1 in RUN: PC <= redirect_pc; if_id_valid <= 0 (flush); no delay slot.
REQ-023 Priority SHALL be rst_n > fault check > redirect_valid > halt_req > stall > advance; redirect overrides a simultaneous stall.
REQ-024 redirect_pc[1:0] != 0 or redirect_pc/4 >= IMEM_WORDS: PC unchanged, if_id_valid <= 0, fault <= 1, go HALTED.
REQ-025 Sequential PC+4 reaching PC/4 >= IMEM_WORDS: the same fault behaviour, checked before the address is presented as a valid fetch.
REQ-026 halt_req=1 in RUN (no redirect, no fault): IF/ID captures the current instruction as in REQ-019, PC holds, go HALTED.
REQ-027 HALTED: PC and IF/ID hold except if_id_valid <= 0 one cycle after entry; exit only via reset.
REQ-028 halted=1 iff state==HALTED; fault remains 1 until reset.
REQ-029 Inputs in START and HALTED SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force state=START, PC=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc4=0, if_id_valid=0, fault=0, halted=0.
REQ-031 Reset asserted mid-operation (any state, including a pending redirect or stall) SHALL discard all in-flight state, with no partial update.
REQ-032 imem_addr SHALL equal RESET_PC throughout reset.

Structure
REQ-033 FSM state enum, instruction width (32), and the PC increment constant (4) SHALL live in the shared CPU package.
REQ-034 The IF/ID register SHALL be a sub-module if_id_reg (enable, flush, async active-low reset), reusable by later pipeline stages.
REQ-035 The block SHALL contain no memory; imem_addr/imem_data connect directly to the instruction memory.

Verification
REQ-036 Reset release, memory holds words 0..3 = 32'h11111111..32'h44444444 -> START one cycle, then if_id_instr 11111111, 22222222, 33333333 with if_id_pc 0, 4, 8 and if_id_valid=1.
REQ-037 stall for 3 cycles at PC=8 -> if_id_* frozen 3 cycles, then resumes at PC 8 with no skip or duplicate.
REQ-038 redirect_valid with redirect_pc=32'h40 while stall=1 -> next cycle if_id_valid=0 and imem_addr=32'h40; the following cycle if_id_pc=32'h40.
REQ-039 redirect_pc=32'h42 -> fault=1, halted=1, if_id_valid=0, imem_addr unchanged; stays until rst_n pulse.
REQ-040 Sequential run to PC=32'hFFC with IMEM_WORDS=1024 -> instruction at 32'hFFC captured, then fault=1 with no fetch at 32'h1000.
REQ-041 rst_n pulsed low mid-run with redirect_valid high -> all outputs at reset values asynchronously; restart at RESET_PC after one START cycle.
